// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tagged entries at issue, collects ALU/LSB results,
// and retires the head entry as a register commit, store release or branch-mispredict flush.
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 readyIn,
  input  logic                 issueFlag,
  input  logic [1:0]           issueType,
  input  logic [4:0]           issueRd,
  input  logic                 issuePredTaken,
  input  logic [31:0]          issueAltPC,
  output logic [ROB_WIDTH-1:0] issueTag,
  output logic                 full,
  input  logic                 aluFlag,
  input  logic [31:0]          aluVal,
  input  logic [ROB_WIDTH-1:0] aluDest,
  input  logic                 lsbFlag,
  input  logic [31:0]          lsbVal,
  input  logic [ROB_WIDTH-1:0] lsbDest,
  input  logic [ROB_WIDTH-1:0] qjTag,
  input  logic [ROB_WIDTH-1:0] qkTag,
  output logic                 qjReady,
  output logic                 qkReady,
  output logic [31:0]          qjVal,
  output logic [31:0]          qkVal,
  output logic                 commitFlag,
  output logic [4:0]           commitRd,
  output logic [31:0]          commitVal,
  output logic [ROB_WIDTH-1:0] commitTag,
  output logic                 storeCommitFlag,
  output logic [ROB_WIDTH-1:0] storeCommitTag,
  output logic                 flushFlag,
  output logic [31:0]          flushPC
);

  localparam int                 ROB_SIZE   = 2 ** ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] COUNT_FULL = ROB_SIZE;
  localparam logic [ROB_WIDTH-1:0] PTR_ONE  = 1;
  localparam logic [1:0] TYPE_REG    = 2'd0;
  localparam logic [1:0] TYPE_STORE  = 2'd1;
  localparam logic [1:0] TYPE_BRANCH = 2'd2;

  logic        busy_reg  [ROB_SIZE];
  logic        ready_reg [ROB_SIZE];
  logic [1:0]  type_reg  [ROB_SIZE];
  logic [4:0]  rd_reg    [ROB_SIZE];
  logic [31:0] val_reg   [ROB_SIZE];
  logic        pred_reg  [ROB_SIZE];
  logic [31:0] alt_reg   [ROB_SIZE];

  logic [ROB_WIDTH-1:0] head_reg;
  logic [ROB_WIDTH-1:0] tail_reg;
  logic [ROB_WIDTH:0]   count_reg;
  logic [ROB_WIDTH:0]   count_next;

  logic [ROB_SIZE-1:0] alu_hit;
  logic [ROB_SIZE-1:0] lsb_hit;
  logic                commit_fire;
  logic                mispredict;
  logic                issue_fire;
  logic [1:0]          head_type;

  assign full     = (count_reg == COUNT_FULL);
  assign issueTag = tail_reg;

  // Results only land on entries that are still in flight.
  genvar gi;
  generate
    for (gi = 0; gi < ROB_SIZE; gi++) begin : g_hit
      assign alu_hit[gi] = aluFlag && (aluDest == ROB_WIDTH'(gi)) && busy_reg[gi];
      assign lsb_hit[gi] = lsbFlag && (lsbDest == ROB_WIDTH'(gi)) && busy_reg[gi];
    end
  endgenerate

  assign head_type   = type_reg[head_reg];
  assign commit_fire = busy_reg[head_reg] && ready_reg[head_reg];
  assign mispredict  = commit_fire && (head_type == TYPE_BRANCH) &&
                       (val_reg[head_reg][0] != pred_reg[head_reg]);
  assign issue_fire  = issueFlag && !full;
  assign count_next  = count_reg + (ROB_WIDTH+1)'(issue_fire) - (ROB_WIDTH+1)'(commit_fire);

  // Operand lookup: stored result first, then same-cycle bypass from the result buses.
  function automatic logic [32:0] lookup(input logic [ROB_WIDTH-1:0] tag);
    logic [32:0] res;
    res = '0;
    if (busy_reg[tag] && ready_reg[tag]) res = {1'b1, val_reg[tag]};
    else if (aluFlag && aluDest == tag)  res = {1'b1, aluVal};
    else if (lsbFlag && lsbDest == tag)  res = {1'b1, lsbVal};
    return res;
  endfunction

  always_comb begin
    {qjReady, qjVal} = lookup(qjTag);
    {qkReady, qkVal} = lookup(qkTag);
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      commitFlag      <= 1'b0;
      commitRd        <= '0;
      commitVal       <= '0;
      commitTag       <= '0;
      storeCommitFlag <= 1'b0;
      storeCommitTag  <= '0;
      flushFlag       <= 1'b0;
      flushPC         <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        busy_reg[i]  <= 1'b0;
        ready_reg[i] <= 1'b0;
        type_reg[i]  <= TYPE_REG;
        rd_reg[i]    <= '0;
        val_reg[i]   <= '0;
        pred_reg[i]  <= 1'b0;
        alt_reg[i]   <= '0;
      end
    end else begin
      commitFlag      <= 1'b0;
      storeCommitFlag <= 1'b0;
      flushFlag       <= 1'b0;
      if (readyIn) begin
        if (commit_fire) begin
          case (head_type)
            TYPE_REG: begin
              commitFlag <= 1'b1;
              commitRd   <= rd_reg[head_reg];
              commitVal  <= val_reg[head_reg];
              commitTag  <= head_reg;
            end
            TYPE_STORE: begin
              storeCommitFlag <= 1'b1;
              storeCommitTag  <= head_reg;
            end
            TYPE_BRANCH: begin
              if (mispredict) begin
                flushFlag <= 1'b1;
                flushPC   <= alt_reg[head_reg];
              end
            end
            default: ;
          endcase
        end

        if (mispredict) begin
          // Flush discards every younger entry, pending writebacks and any concurrent issue.
          head_reg  <= '0;
          tail_reg  <= '0;
          count_reg <= '0;
          for (int i = 0; i < ROB_SIZE; i++) busy_reg[i] <= 1'b0;
        end else begin
          for (int i = 0; i < ROB_SIZE; i++) begin
            if (alu_hit[i]) begin
              ready_reg[i] <= 1'b1;
              val_reg[i]   <= aluVal;
            end else if (lsb_hit[i]) begin
              ready_reg[i] <= 1'b1;
              val_reg[i]   <= lsbVal;
            end
          end
          if (commit_fire) begin
            busy_reg[head_reg] <= 1'b0;
            head_reg           <= head_reg + PTR_ONE;
          end
          if (issue_fire) begin
            busy_reg[tail_reg]  <= 1'b1;
            ready_reg[tail_reg] <= 1'b0;
            type_reg[tail_reg]  <= issueType;
            rd_reg[tail_reg]    <= issueRd;
            pred_reg[tail_reg]  <= issuePredTaken;
            alt_reg[tail_reg]   <= issueAltPC;
            tail_reg            <= tail_reg + PTR_ONE;
          end
          count_reg <= count_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: inputs change and outputs are sampled on the falling edge.
module tb_reorder_buffer;
  localparam int W = 4;

  logic         clockIn = 1'b0;
  logic         resetIn, readyIn, issueFlag, issuePredTaken;
  logic [1:0]   issueType;
  logic [4:0]   issueRd;
  logic [31:0]  issueAltPC;
  logic [W-1:0] issueTag;
  logic         full;
  logic         aluFlag, lsbFlag;
  logic [31:0]  aluVal, lsbVal;
  logic [W-1:0] aluDest, lsbDest, qjTag, qkTag;
  logic         qjReady, qkReady;
  logic [31:0]  qjVal, qkVal;
  logic         commitFlag;
  logic [4:0]   commitRd;
  logic [31:0]  commitVal;
  logic [W-1:0] commitTag;
  logic         storeCommitFlag;
  logic [W-1:0] storeCommitTag;
  logic         flushFlag;
  logic [31:0]  flushPC;

  int n_checks = 0;
  int n_fail   = 0;

  reorder_buffer #(.ROB_WIDTH(W)) dut (
    .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn),
    .issueFlag(issueFlag), .issueType(issueType), .issueRd(issueRd),
    .issuePredTaken(issuePredTaken), .issueAltPC(issueAltPC),
    .issueTag(issueTag), .full(full),
    .aluFlag(aluFlag), .aluVal(aluVal), .aluDest(aluDest),
    .lsbFlag(lsbFlag), .lsbVal(lsbVal), .lsbDest(lsbDest),
    .qjTag(qjTag), .qkTag(qkTag),
    .qjReady(qjReady), .qkReady(qkReady), .qjVal(qjVal), .qkVal(qkVal),
    .commitFlag(commitFlag), .commitRd(commitRd), .commitVal(commitVal), .commitTag(commitTag),
    .storeCommitFlag(storeCommitFlag), .storeCommitTag(storeCommitTag),
    .flushFlag(flushFlag), .flushPC(flushPC)
  );

  always #5 clockIn = ~clockIn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clockIn);
    @(negedge clockIn);
  endtask

  task automatic idle();
    issueFlag = 1'b0; issueType = 2'd0; issueRd = '0; issuePredTaken = 1'b0; issueAltPC = '0;
    aluFlag = 1'b0; aluVal = '0; aluDest = '0;
    lsbFlag = 1'b0; lsbVal = '0; lsbDest = '0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic pred, input logic [31:0] alt);
    issueFlag = 1'b1; issueType = t; issueRd = rd; issuePredTaken = pred; issueAltPC = alt;
  endtask

  task automatic alu(input logic [W-1:0] d, input logic [31:0] v);
    aluFlag = 1'b1; aluDest = d; aluVal = v;
  endtask

  task automatic lsb(input logic [W-1:0] d, input logic [31:0] v);
    lsbFlag = 1'b1; lsbDest = d; lsbVal = v;
  endtask

  task automatic do_reset();
    resetIn = 1'b0;
    #1;
    chk("rst_commitFlag", 32'(commitFlag), 0);
    chk("rst_commitVal", commitVal, 0);
    chk("rst_storeFlag", 32'(storeCommitFlag), 0);
    chk("rst_flushFlag", 32'(flushFlag), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_issueTag", 32'(issueTag), 0);
    @(negedge clockIn);
    idle();
    resetIn = 1'b1;
  endtask

  initial begin
    resetIn = 1'b0; readyIn = 1'b1; qjTag = '0; qkTag = '0;
    idle();
    @(negedge clockIn);
    do_reset();

    // Single REG issue, ALU writeback, commit
    issue(2'd0, 5'd5, 1'b0, 32'h0);
    step();
    chk("t1_issueTag", 32'(issueTag), 1);
    idle(); alu(4'd0, 32'h1234); qjTag = 4'd0;
    #1;
    chk("t1_bypass_rdy", 32'(qjReady), 1);
    chk("t1_bypass_val", qjVal, 32'h1234);
    @(negedge clockIn);
    idle();
    #1;
    chk("t1_entry_rdy", 32'(qjReady), 1);
    chk("t1_entry_val", qjVal, 32'h1234);
    chk("t1_no_early_commit", 32'(commitFlag), 0);
    step();
    chk("t1_commitFlag", 32'(commitFlag), 1);
    chk("t1_commitRd", 32'(commitRd), 5);
    chk("t1_commitVal", commitVal, 32'h1234);
    chk("t1_commitTag", 32'(commitTag), 0);
    chk("t1_retired_lookup", 32'(qjReady), 0);
    // Asynchronous reset while a commit pulse is visible
    resetIn = 1'b0;
    #1;
    chk("t1_async_commitFlag", 32'(commitFlag), 0);
    chk("t1_async_commitRd", 32'(commitRd), 0);
    chk("t1_async_issueTag", 32'(issueTag), 0);
    @(negedge clockIn);
    resetIn = 1'b1;

    // STORE commit
    issue(2'd1, 5'd0, 1'b0, 32'h0);
    step();
    idle(); lsb(4'd0, 32'h0);
    step();
    idle();
    step();
    chk("t2_storeFlag", 32'(storeCommitFlag), 1);
    chk("t2_storeTag", 32'(storeCommitTag), 0);
    chk("t2_commitFlag", 32'(commitFlag), 0);
    step();
    chk("t2_store_pulse", 32'(storeCommitFlag), 0);

    // Fill to capacity, blocked issue, blocked issue during head commit
    do_reset();
    for (int i = 0; i < 16; i++) begin
      issue(2'd0, 5'(i), 1'b0, 32'h0);
      step();
    end
    chk("t3_full", 32'(full), 1);
    chk("t3_tail_wrap", 32'(issueTag), 0);
    step();
    chk("t3_17th_ignored", 32'(issueTag), 0);
    chk("t3_still_full", 32'(full), 1);
    idle(); alu(4'd0, 32'h7);
    step();
    chk("t3_full_after_wb", 32'(full), 1);
    idle(); issue(2'd0, 5'd1, 1'b0, 32'h0);
    step();
    chk("t3_commitFlag", 32'(commitFlag), 1);
    chk("t3_commitTag", 32'(commitTag), 0);
    chk("t3_full_drop", 32'(full), 0);
    chk("t3_issue_blocked_at_full", 32'(issueTag), 0);
    step();
    chk("t3_refill_tag", 32'(issueTag), 1);
    chk("t3_refull", 32'(full), 1);
    idle();
    do_reset();
    step();
    chk("t3_discard_commit", 32'(commitFlag), 0);
    chk("t3_discard_full", 32'(full), 0);

    // Wrap-around: retire tags 0..14 one by one, then commit tags 15 then 0
    for (int i = 0; i < 15; i++) begin
      issue(2'd0, 5'd1, 1'b0, 32'h0);
      step();
      idle(); alu(4'(i), 32'(i));
      step();
      idle();
      step();
      chk("t4_seq_tag", 32'(commitTag), 32'(i));
    end
    chk("t4_tag_before_wrap", 32'(issueTag), 15);
    issue(2'd0, 5'd3, 1'b0, 32'h0);
    step();
    chk("t4_issueTag_wrap", 32'(issueTag), 0);
    issue(2'd0, 5'd4, 1'b0, 32'h0);
    step();
    chk("t4_issueTag_after_wrap", 32'(issueTag), 1);
    idle(); alu(4'd15, 32'hA); lsb(4'd0, 32'hB);
    step();
    idle();
    step();
    chk("t4_commit15_tag", 32'(commitTag), 15);
    chk("t4_commit15_val", commitVal, 32'hA);
    chk("t4_commit15_rd", 32'(commitRd), 3);
    step();
    chk("t4_commit0_flag", 32'(commitFlag), 1);
    chk("t4_commit0_tag", 32'(commitTag), 0);
    chk("t4_commit0_val", commitVal, 32'hB);

    // Mispredicted branch flushes younger completed entries and a concurrent issue
    do_reset();
    issue(2'd2, 5'd0, 1'b0, 32'h100);
    step();
    issue(2'd0, 5'd7, 1'b0, 32'h0);
    step();
    idle(); alu(4'd0, 32'h1); lsb(4'd1, 32'h77);
    step();
    idle(); issue(2'd0, 5'd9, 1'b0, 32'h0);
    step();
    chk("t5_flushFlag", 32'(flushFlag), 1);
    chk("t5_flushPC", flushPC, 32'h100);
    chk("t5_flush_issueTag", 32'(issueTag), 0);
    chk("t5_flush_no_commit", 32'(commitFlag), 0);
    idle();
    step();
    chk("t5_flush_pulse", 32'(flushFlag), 0);
    chk("t5_younger_dropped", 32'(commitFlag), 0);
    chk("t5_issue_discarded", 32'(issueTag), 0);
    step();
    chk("t5_younger_dropped2", 32'(commitFlag), 0);
    issue(2'd2, 5'd0, 1'b1, 32'h200);
    step();
    idle(); alu(4'd0, 32'h1);
    step();
    idle();
    step();
    chk("t5_good_branch_flush", 32'(flushFlag), 0);
    chk("t5_good_branch_commit", 32'(commitFlag), 0);
    chk("t5_good_branch_store", 32'(storeCommitFlag), 0);
    chk("t5_good_branch_retired", 32'(issueTag), 1);

    // Out-of-order writeback, in-order retirement
    do_reset();
    issue(2'd0, 5'd10, 1'b0, 32'h0); step();
    issue(2'd0, 5'd0,  1'b0, 32'h0); step();
    issue(2'd0, 5'd12, 1'b0, 32'h0); step();
    issue(2'd0, 5'd13, 1'b0, 32'h0); step();
    idle(); alu(4'd0, 32'h20);
    step();
    idle(); alu(4'd2, 32'h22); lsb(4'd3, 32'h33);
    step();
    chk("t6_commit0_tag", 32'(commitTag), 0);
    chk("t6_commit0_val", commitVal, 32'h20);
    idle();
    step();
    chk("t6_wait_tag1_a", 32'(commitFlag), 0);
    alu(4'd1, 32'h11);
    step();
    chk("t6_wait_tag1_b", 32'(commitFlag), 0);
    idle();
    step();
    chk("t6_commit1_flag", 32'(commitFlag), 1);
    chk("t6_commit1_tag", 32'(commitTag), 1);
    chk("t6_commit1_rd0", 32'(commitRd), 0);
    chk("t6_commit1_val", commitVal, 32'h11);
    step();
    chk("t6_commit2_tag", 32'(commitTag), 2);
    chk("t6_commit2_val", commitVal, 32'h22);
    step();
    chk("t6_commit3_flag", 32'(commitFlag), 1);
    chk("t6_commit3_tag", 32'(commitTag), 3);
    chk("t6_commit3_val", commitVal, 32'h33);
    step();
    chk("t6_drained", 32'(commitFlag), 0);
    // Same-tag ALU and LSB writeback: ALU value wins
    issue(2'd0, 5'd14, 1'b0, 32'h0);
    step();
    idle(); alu(4'd4, 32'hAA); lsb(4'd4, 32'hBB);
    step();
    idle(); alu(4'd9, 32'h99);
    step();
    chk("t6_alu_wins_tag", 32'(commitTag), 4);
    chk("t6_alu_wins_val", commitVal, 32'hAA);
    idle(); qjTag = 4'd9;
    #1;
    chk("t6_nonbusy_rdy", 32'(qjReady), 0);
    chk("t6_nonbusy_val", qjVal, 0);
    // Stall: no issue, no writeback, no commit while readyIn is low
    @(negedge clockIn);
    issue(2'd0, 5'd15, 1'b0, 32'h0);
    step();
    readyIn = 1'b0; issue(2'd0, 5'd1, 1'b0, 32'h0); alu(4'd5, 32'h55);
    step();
    chk("t7_stall_issue", 32'(issueTag), 6);
    chk("t7_stall_commit", 32'(commitFlag), 0);
    readyIn = 1'b1; issueFlag = 1'b0;
    step();
    chk("t7_resume_no_commit", 32'(commitFlag), 0);
    chk("t7_resume_issueTag", 32'(issueTag), 6);
    idle();
    step();
    chk("t7_commit_flag", 32'(commitFlag), 1);
    chk("t7_commit_tag", 32'(commitTag), 5);
    chk("t7_commit_val", commitVal, 32'h55);
    chk("t7_commit_rd", 32'(commitRd), 15);
    step();
    chk("t7_pulse", 32'(commitFlag), 0);

    // Bypass lookups from an empty buffer
    do_reset();
    qjTag = 4'd4; alu(4'd4, 32'h55);
    qkTag = 4'd6; lsb(4'd6, 32'h66);
    #1;
    chk("t8_qj_rdy", 32'(qjReady), 1);
    chk("t8_qj_val", qjVal, 32'h55);
    chk("t8_qk_rdy", 32'(qkReady), 1);
    chk("t8_qk_val", qkVal, 32'h66);
    qkTag = 4'd7;
    #1;
    chk("t8_qk_miss_rdy", 32'(qkReady), 0);
    chk("t8_qk_miss_val", qkVal, 0);
    @(negedge clockIn);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter ROB_WIDTH, default 4, tag width; depth ROB_SIZE = 2**ROB_WIDTH entries.
REQ-002 clockIn  in  1  single clock; all state updates on rising edge.
REQ-003 resetIn  in  1  asynchronous, active-low reset.
REQ-004 readyIn  in  1  global enable; low = stall.
REQ-005 issueFlag  in  1  allocate one entry this cycle.
REQ-006 issueType  in  2  0=REG (writes rd), 1=STORE, 2=BRANCH.
REQ-007 issueRd  in  5  destination register (REG only).
REQ-008 issuePredTaken  in  1  predicted direction (BRANCH only).
REQ-009 issueAltPC  in  32  PC to restart at on mispredict (BRANCH only).
REQ-010 issueTag  out  ROB_WIDTH  combinational tag of the tail slot.
REQ-011 full  out  1  combinational, count == ROB_SIZE.
REQ-012 aluFlag / aluVal / aluDest  in  1/32/ROB_WIDTH  ALU result bus (RS output).
REQ-013 lsbFlag / lsbVal / lsbDest  in  1/32/ROB_WIDTH  load result, or store-resolved notice.
REQ-014 qjTag, qkTag  in  ROB_WIDTH each  operand lookups from issue logic.
REQ-015 qjReady, qkReady  out  1 each; qjVal, qkVal  out  32 each  combinational lookup results.
REQ-016 commitFlag / commitRd / commitVal / commitTag  out  1/5/32/ROB_WIDTH  registered REG commit to register file.
REQ-017 storeCommitFlag / storeCommitTag  out  1/ROB_WIDTH  registered; releases store in LSB.
REQ-018 flushFlag / flushPC  out  1/32  registered mispredict flush.

Function
REQ-019 Per entry: busy, ready, type, rd, val[31:0], predTaken, altPC; pointers head, tail (ROB_WIDTH bits, wrap modulo ROB_SIZE); count (ROB_WIDTH+1 bits).
REQ-020 readyIn low: no state change; commitFlag, storeCommitFlag, flushFlag driven 0 on that edge.
REQ-021 Issue: issueFlag & ~full -> entry[tail] busy=1, ready=0, fields captured, tail+1; issueFlag while full is ignored.
REQ-022 Writeback: aluFlag with busy entry[aluDest] -> ready=1, val=aluVal; same for lsb; both in one cycle to different tags both apply; same tag -> ALU value wins; non-busy tag ignored.
REQ-023 BRANCH taken outcome = val[0] of its ALU result.
REQ-024 Commit: at most one per cycle; if entry[head] busy & ready, it retires on that edge: busy=0, head+1, count-1.
REQ-025 REG commit: next cycle commitFlag=1, commitRd, commitVal, commitTag=head; rd==0 still reported.
REQ-026 STORE commit: storeCommitFlag=1, storeCommitTag=head; commitFlag=0.
REQ-027 BRANCH commit with val[0]==predTaken: no output pulse.
REQ-028 BRANCH commit with val[0]!=predTaken: flushFlag=1, flushPC=altPC; on that same edge all busy cleared, head=tail=0, count=0; a concurrent issue is discarded.
REQ-029 Simultaneous issue and commit: count unchanged; issue at full is blocked even if head commits that cycle.
REQ-030 Pulse outputs are high for exactly one cycle per event.
REQ-031 Lookup: qjReady=1 if entry[qjTag] busy & ready (qjVal=val), else if aluFlag & aluDest==qjTag (qjVal=aluVal), else if lsbFlag & lsbDest==qjTag (qjVal=lsbVal); else qjReady=0, qjVal=0; qk identical.
REQ-032 Commit latency: result written at edge N is committed at edge N+1 if at head, outputs visible after edge N+1.

Reset
REQ-033 resetIn low asynchronously: busy all 0, head=tail=0, count=0, all output registers 0; full=0, issueTag=0.
REQ-034 Reset mid-operation discards all in-flight entries; no commit pulse emitted.

Verification
REQ-035 Issue REG rd=5 tag 0, aluFlag dest 0 val 0x1234 -> next edge commitFlag=1, commitRd=5, commitVal=0x1234, commitTag=0.
REQ-036 Issue 16 entries without writeback -> full=1; 17th issueFlag ignored, tail stays 0; complete tag 0 -> full drops after commit.
REQ-037 Fill to tag 15, retire all, issue again -> issueTag wraps to 0, in-order commit tags 15,0.
REQ-038 BRANCH predTaken=0, altPC=0x100, ALU val=1 -> flushFlag=1, flushPC=0x100, count=0; younger completed entries never commit.
REQ-039 Writeback tags 2 (ALU) and 3 (LSB) out of order before tag 1 -> no commit until tag 1 ready, then commits 1,2,3 on consecutive cycles.
REQ-040 qjTag=4 with aluFlag dest 4 val 0x55 same cycle -> qjReady=1, qjVal=0x55; resetIn low mid-stream -> all outputs 0 immediately.
